// File: rtl/neander_x_control_if.sv
// NEANDER-X control <-> datapath bundle: decode inputs and load/select strobes.
// master = control unit, slave = datapath.
interface neander_x_control_if;
    logic [3:0] opcode;
    logic       flagN;
    logic       flagZ;
    logic       mem_read;
    logic       mem_write;
    logic       pc_inc;
    logic       pc_load;
    logic       ac_load;
    logic       ri_load;
    logic       rem_load;
    logic       rdm_load;
    logic       nz_load;
    logic       addr_sel_pc;
    logic [1:0] alu_op;
    logic       io_write_ctrl;

    modport master (
        input  opcode, flagN, flagZ,
        output mem_read, mem_write, pc_inc, pc_load,
        output ac_load, ri_load, rem_load, rdm_load,
        output nz_load, addr_sel_pc, alu_op, io_write_ctrl
    );

    modport slave (
        output opcode, flagN, flagZ,
        input  mem_read, mem_write, pc_inc, pc_load,
        input  ac_load, ri_load, rem_load, rdm_load,
        input  nz_load, addr_sel_pc, alu_op, io_write_ctrl
    );
endinterface

// File: rtl/neander_x_control.sv
// NEANDER-X multi-cycle control FSM with run gate, HALT state and state visibility.
// Strobes are decoded from the registered state, RI opcode and N/Z flags.
module neander_x_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        run,
    neander_x_control_if.master         bus,
    output logic                        halted,
    output logic                        instr_done,
    output logic [3:0]                  dbg_state
);
    localparam logic [3:0] S_F0   = 4'd0;
    localparam logic [3:0] S_F1   = 4'd1;
    localparam logic [3:0] S_F2   = 4'd2;
    localparam logic [3:0] S_DEC  = 4'd3;
    localparam logic [3:0] S_OP   = 4'd4;
    localparam logic [3:0] S_IND  = 4'd5;
    localparam logic [3:0] S_EXE  = 4'd6;
    localparam logic [3:0] S_JMP  = 4'd7;
    localparam logic [3:0] S_IOX  = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_IL7 = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_ILB = 4'hB;
    localparam logic [3:0] OP_IN  = 4'hC;
    localparam logic [3:0] OP_OUT = 4'hD;
    localparam logic [3:0] OP_LDI = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [3:0] state;
    logic [3:0] state_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_F0;
        else          state <= state_nx;
    end

    assign dbg_state = state;

    // Asserting reset_n low forces every strobe off at once, even the
    // run-gated F0 strobes, so an aborted instruction leaves nothing half-done.
    always_comb begin
        state_nx          = state;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.pc_inc        = 1'b0;
        bus.pc_load       = 1'b0;
        bus.ac_load       = 1'b0;
        bus.ri_load       = 1'b0;
        bus.rem_load      = 1'b0;
        bus.rdm_load      = 1'b0;
        bus.nz_load       = 1'b0;
        bus.addr_sel_pc   = 1'b0;
        bus.alu_op        = 2'b00;
        bus.io_write_ctrl = 1'b0;
        halted            = 1'b0;
        instr_done        = 1'b0;
        if (reset_n) begin
            case (state)
                S_F0: if (run) begin
                    bus.rem_load    = 1'b1;
                    bus.addr_sel_pc = 1'b1;
                    state_nx        = S_F1;
                end
                S_F1: begin
                    bus.mem_read = 1'b1;
                    bus.rdm_load = 1'b1;
                    bus.pc_inc   = 1'b1;
                    state_nx     = S_F2;
                end
                S_F2: begin
                    bus.ri_load = 1'b1;
                    state_nx    = S_DEC;
                end
                S_DEC: begin
                    bus.rem_load    = 1'b1;
                    bus.addr_sel_pc = 1'b1;
                    state_nx        = S_OP;
                    case (bus.opcode)
                        OP_NOP: begin
                            bus.rem_load    = 1'b0;
                            bus.addr_sel_pc = 1'b0;
                            instr_done      = 1'b1;
                            state_nx        = S_F0;
                        end
                        OP_NOT: begin
                            bus.rem_load    = 1'b0;
                            bus.addr_sel_pc = 1'b0;
                            bus.ac_load     = 1'b1;
                            bus.nz_load     = 1'b1;
                            bus.alu_op      = 2'b11;
                            instr_done      = 1'b1;
                            state_nx        = S_F0;
                        end
                        OP_HLT, OP_IL7, OP_ILB: begin
                            bus.rem_load    = 1'b0;
                            bus.addr_sel_pc = 1'b0;
                            instr_done      = 1'b1;
                            if (bus.opcode == OP_HLT || HALT_ON_ILLEGAL)
                                state_nx = S_HALT;
                            else
                                state_nx = S_F0;
                        end
                        OP_JN, OP_JZ: begin
                            if ((bus.opcode == OP_JN && !bus.flagN) ||
                                (bus.opcode == OP_JZ && !bus.flagZ)) begin
                                bus.rem_load    = 1'b0;
                                bus.addr_sel_pc = 1'b0;
                                bus.pc_inc      = 1'b1;
                                instr_done      = 1'b1;
                                state_nx        = S_F0;
                            end
                        end
                        default: ;
                    endcase
                end
                S_OP: begin
                    bus.mem_read = 1'b1;
                    bus.rdm_load = 1'b1;
                    bus.pc_inc   = 1'b1;
                    case (bus.opcode)
                        OP_LDI: begin
                            bus.ac_load = 1'b1;
                            bus.nz_load = 1'b1;
                            instr_done  = 1'b1;
                            state_nx    = S_F0;
                        end
                        OP_JMP, OP_JN, OP_JZ: state_nx = S_JMP;
                        OP_IN, OP_OUT:        state_nx = S_IOX;
                        default:              state_nx = S_IND;
                    endcase
                end
                S_IND: begin
                    bus.rem_load = 1'b1;
                    state_nx     = S_EXE;
                end
                S_EXE: begin
                    instr_done = 1'b1;
                    state_nx   = S_F0;
                    case (bus.opcode)
                        OP_STA: bus.mem_write = 1'b1;
                        OP_LDA, OP_ADD, OP_OR, OP_AND: begin
                            bus.mem_read = 1'b1;
                            bus.ac_load  = 1'b1;
                            bus.nz_load  = 1'b1;
                            if (bus.opcode == OP_OR)  bus.alu_op = 2'b10;
                            if (bus.opcode == OP_AND) bus.alu_op = 2'b01;
                        end
                        default: ;
                    endcase
                end
                S_JMP: begin
                    bus.pc_load = 1'b1;
                    instr_done  = 1'b1;
                    state_nx    = S_F0;
                end
                S_IOX: begin
                    instr_done = 1'b1;
                    state_nx   = S_F0;
                    if (bus.opcode == OP_IN) begin
                        bus.ac_load = 1'b1;
                        bus.nz_load = 1'b1;
                    end else if (bus.opcode == OP_OUT) begin
                        bus.io_write_ctrl = 1'b1;
                    end
                end
                S_HALT: halted = 1'b1;
                default: state_nx = S_F0;
            endcase
        end
    end
endmodule

// File: tb/tb_neander_x_control.sv
// Scoreboard bench: stimulus pushes hand-written per-cycle output vectors,
// a negedge monitor pops and compares them for both HALT_ON_ILLEGAL variants.
module tb_neander_x_control;
    localparam logic [18:0] RD  = 19'd1 << 18;
    localparam logic [18:0] WR  = 19'd1 << 17;
    localparam logic [18:0] PI  = 19'd1 << 16;
    localparam logic [18:0] PL  = 19'd1 << 15;
    localparam logic [18:0] AL  = 19'd1 << 14;
    localparam logic [18:0] RIL = 19'd1 << 13;
    localparam logic [18:0] RL  = 19'd1 << 12;
    localparam logic [18:0] RDL = 19'd1 << 11;
    localparam logic [18:0] NZ  = 19'd1 << 10;
    localparam logic [18:0] AP  = 19'd1 << 9;
    localparam logic [18:0] A1  = 19'd1 << 7;
    localparam logic [18:0] A2  = 19'd2 << 7;
    localparam logic [18:0] A3  = 19'd3 << 7;
    localparam logic [18:0] IO  = 19'd1 << 6;
    localparam logic [18:0] HL  = 19'd1 << 5;
    localparam logic [18:0] DN  = 19'd1 << 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       halted0, halted1, done0, done1;
    logic [3:0] st0, st1;
    int         tests = 0;
    int         fails = 0;
    logic [18:0] q0[$];
    logic [18:0] q1[$];
    string       tag;

    neander_x_control_if bus0 ();
    neander_x_control_if bus1 ();

    neander_x_control #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .run(run), .bus(bus0.master),
        .halted(halted0), .instr_done(done0), .dbg_state(st0)
    );
    neander_x_control #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .run(run), .bus(bus1.master),
        .halted(halted1), .instr_done(done1), .dbg_state(st1)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] pack(
        input logic [13:0] s, input logic h, input logic d, input logic [3:0] st
    );
        return {s, h, d, st};
    endfunction

    always @(negedge clk) begin
        logic [18:0] a0, a1, e0, e1;
        a0 = pack({bus0.mem_read, bus0.mem_write, bus0.pc_inc, bus0.pc_load,
                   bus0.ac_load, bus0.ri_load, bus0.rem_load, bus0.rdm_load,
                   bus0.nz_load, bus0.addr_sel_pc, bus0.alu_op,
                   bus0.io_write_ctrl}, halted0, done0, st0);
        a1 = pack({bus1.mem_read, bus1.mem_write, bus1.pc_inc, bus1.pc_load,
                   bus1.ac_load, bus1.ri_load, bus1.rem_load, bus1.rdm_load,
                   bus1.nz_load, bus1.addr_sel_pc, bus1.alu_op,
                   bus1.io_write_ctrl}, halted1, done1, st1);
        if (q0.size() > 0 && q1.size() > 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            tests++;
            if (a0 !== e0) begin
                fails++;
                $display("FAIL %s dut0: got %h want %h", tag, a0, e0);
            end
            tests++;
            if (a1 !== e1) begin
                fails++;
                $display("FAIL %s dut1: got %h want %h", tag, a1, e1);
            end
            tests++;
            if ((a0[18] & a0[17]) | (a0[16] & a0[15])) begin
                fails++;
                $display("FAIL %s strobe_excl: got %h want no rd&wr/inc&load", tag, a0);
            end
        end
    end

    task automatic step2(input logic [18:0] e0, input logic [18:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [18:0] e);
        step2(e, e);
    endtask

    task automatic set_op(input logic [3:0] op, input logic n, input logic z);
        bus0.opcode = op; bus1.opcode = op;
        bus0.flagN = n;   bus1.flagN = n;
        bus0.flagZ = z;   bus1.flagZ = z;
    endtask

    task automatic fetch(input string name, input logic [3:0] op,
                         input logic n, input logic z);
        tag = name;
        set_op(op, n, z);
        run = 1'b1;
        step(RL | AP | 19'd0);
        run = 1'b0;
        step(RD | RDL | PI | 19'd1);
        step(RIL | 19'd2);
    endtask

    task automatic mem_instr(input string name, input logic [3:0] op,
                             input logic [18:0] exe);
        fetch(name, op, 1'b0, 1'b0);
        step(RL | AP | 19'd3);
        step(RD | RDL | PI | 19'd4);
        step(RL | 19'd5);
        step(exe | DN | 19'd6);
    endtask

    task automatic jmp_instr(input string name, input logic [3:0] op,
                             input logic n, input logic z);
        fetch(name, op, n, z);
        step(RL | AP | 19'd3);
        step(RD | RDL | PI | 19'd4);
        step(PL | DN | 19'd7);
    endtask

    task automatic io_instr(input string name, input logic [3:0] op,
                            input logic [18:0] iox);
        fetch(name, op, 1'b0, 1'b0);
        step(RL | AP | 19'd3);
        step(RD | RDL | PI | 19'd4);
        step(iox | DN | 19'd8);
    endtask

    task automatic do_reset();
        tag = "reset";
        reset_n = 1'b0;
        run = 1'b1;
        step(19'd0);
        reset_n = 1'b1;
        run = 1'b0;
        step(19'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        run = 1'b1;
        tag = "init";
        set_op(4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        step(19'd0);
        reset_n = 1'b1;
        run = 1'b0;
        step(19'd0);

        mem_instr("lda", 4'h2, RD | AL | NZ);
        mem_instr("add", 4'h3, RD | AL | NZ);
        mem_instr("and", 4'h5, RD | AL | NZ | A1);
        mem_instr("or",  4'h4, RD | AL | NZ | A2);
        mem_instr("sta", 4'h1, WR);

        fetch("not", 4'h6, 1'b0, 1'b0);
        step(AL | NZ | A3 | DN | 19'd3);
        fetch("nop", 4'h0, 1'b0, 1'b0);
        step(DN | 19'd3);

        jmp_instr("jmp", 4'h8, 1'b0, 1'b0);
        jmp_instr("jn_taken", 4'h9, 1'b1, 1'b0);
        fetch("jn_skip", 4'h9, 1'b0, 1'b1);
        step(PI | DN | 19'd3);
        jmp_instr("jz_taken", 4'hA, 1'b0, 1'b1);
        fetch("jz_skip", 4'hA, 1'b1, 1'b0);
        step(PI | DN | 19'd3);

        io_instr("in", 4'hC, AL | NZ);
        io_instr("out", 4'hD, IO);

        fetch("ldi", 4'hE, 1'b0, 1'b0);
        step(RL | AP | 19'd3);
        step(RD | RDL | PI | AL | NZ | DN | 19'd4);

        tag = "idle";
        step(19'd0);

        fetch("illegal7", 4'h7, 1'b0, 1'b0);
        step(DN | 19'd3);
        step2(19'd0, HL | 19'd9);
        run = 1'b1;
        step2(RL | AP | 19'd0, HL | 19'd9);
        run = 1'b0;
        step2(RD | RDL | PI | 19'd1, HL | 19'd9);
        step2(RIL | 19'd2, HL | 19'd9);
        step2(DN | 19'd3, HL | 19'd9);
        do_reset();

        fetch("hlt", 4'hF, 1'b0, 1'b0);
        step(DN | 19'd3);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            step(HL | 19'd9);
        end
        do_reset();

        fetch("rst_mid_exe", 4'h2, 1'b0, 1'b0);
        step(RL | AP | 19'd3);
        step(RD | RDL | PI | 19'd4);
        step(RL | 19'd5);
        reset_n = 1'b0;
        step(19'd0);
        reset_n = 1'b1;
        run = 1'b0;
        tag = "idle_after_rst";
        for (int i = 0; i < 5; i++) step(19'd0);

        mem_instr("lda_again", 4'h2, RD | AL | NZ);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
